// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: ALU ops, opcodes,
// operand/result selects, state enum and the branch-condition helper.
package ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b0011;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    // Zero base operand, so LUI passes the immediate through the adder.
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JUMP, LUI, TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_BRANCH, ALUOP_RTYPE, ALUOP_ITYPE
    } alu_op_t;

    // ALU computes SUB/SLT/SLTU; zero=1 means equal or "not less than".
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            3'b000, 3'b101, 3'b111: taken = zero;
            3'b001, 3'b100, 3'b110: taken = ~zero;
            default:                taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps the instruction class plus funct3/funct7b5
// onto the 4-bit ALU operation code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    // bit 30 of an I-type is immediate data, so ADDI never subtracts
                    3'b000:  alu_control = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: sequences fetch, decode, memory, execute,
// writeback and branch/jump states and drives the datapath strobes.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4 when memory ready
// DECODE   | branch target (old PC + imm) into ALU-out, dispatch on opcode
// MEMADR   | rs1 + imm address for load/store
// MEMREAD  | hold load access until mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | hold store access until mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU-out to rd
// BRANCH   | compare rs1/rs2, PC <= target if taken
// JUMP     | rd <= link address, PC <= jump target
// LUI      | rd <= immediate
// TRAP     | unsupported instruction, parked until reset
module control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    is_load;
    logic    is_jalr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            is_load <= 1'b0;
            is_jalr <= 1'b0;
        end else begin
            state <= state_next;
            // Instruction class captured once so later states do not depend on the IR
            if (state == DECODE) begin
                is_load <= (opcode == OP_LOAD);
                is_jalr <= (opcode == OP_JALR);
            end
        end
    end

    always_comb begin
        state_next = state;
        alu_op     = ALUOP_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        unique case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL, OP_JALR:   state_next = JUMP;
                    OP_LUI:            state_next = LUI;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = is_load ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALUOP_RTYPE;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALUOP_ITYPE;
                state_next = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                result_src = RES_ALUOUT;
                alu_op     = ALUOP_BRANCH;
                pc_write   = branch_taken(funct3, zero);
                state_next = (funct3[2:1] == 2'b01) ? TRAP : FETCH;
            end
            JUMP: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (is_jalr) begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    result_src = RES_ALU;
                end else begin
                    // Link address old PC + 4 on the ALU; PC takes the DECODE target
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALUOUT;
                end
                state_next = FETCH;
            end
            LUI: begin
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Reset silences the outputs immediately, not just at the next edge
        if (rst) begin
            alu_op     = ALUOP_ADD;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_RS2;
            result_src = RES_ALUOUT;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle vector table of instruction fields,
// memory handshake and hand-computed control outputs, plus reset corner cases.
module tb_control_fsm;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic       adr;
        logic       ir;
        logic       pcw;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       b5;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_write, mem_read, mem_write, reg_write, illegal;
    outs_t      act;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    assign act = '{alu: alu_control, sa: alu_src_a, sb: alu_src_b, rs: result_src,
                   adr: adr_src, ir: ir_write, pcw: pc_write, mr: mem_read,
                   mw: mem_write, rw: reg_write, ill: illegal};

    // strobes packed as {adr, ir, pc_write, mem_read, mem_write, reg_write, illegal}
    function automatic outs_t mk(input logic [3:0] alu, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] rs,
                                 input logic [6:0] st);
        outs_t o;
        o = {alu, sa, sb, rs, st};
        return o;
    endfunction

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, B = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUIOP = 7'b0110111, BAD = 7'h7F;

    outs_t e_f_rdy, e_f_wait, e_dec, e_wb, e_madr, e_mrd, e_mwr, e_mwb, e_trap, e_zero;
    outs_t e_jal, e_jalr, e_lui;

    function automatic outs_t e_execr(input logic [3:0] alu);
        return mk(alu, 2'b10, 2'b00, 2'b00, 7'b0000000);
    endfunction
    function automatic outs_t e_execi(input logic [3:0] alu);
        return mk(alu, 2'b10, 2'b01, 2'b00, 7'b0000000);
    endfunction
    function automatic outs_t e_br(input logic [3:0] alu, input logic pc);
        return mk(alu, 2'b10, 2'b00, 2'b00, {2'b00, pc, 4'b0000});
    endfunction

    task automatic row(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic b5, input logic z, input logic rdy, input outs_t exp);
        vec_t v;
        v.name = name; v.opc = opc; v.f3 = f3; v.b5 = b5; v.zero = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b5);
        row({name, "_fetch"},  opc, f3, b5, 1'b0, 1'b1, e_f_rdy);
        row({name, "_decode"}, opc, f3, b5, 1'b0, 1'b1, e_dec);
    endtask

    task automatic check(input string name, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Entered right after a falling edge; leaves right after a falling edge.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].opc; funct3 = vecs[i].f3; funct7b5 = vecs[i].b5;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, vecs[i].exp);
            @(negedge clk);
        end
        vecs.delete();
    endtask

    initial begin
        e_f_rdy  = mk(4'b0010, 2'b00, 2'b10, 2'b10, 7'b0111000);
        e_f_wait = mk(4'b0010, 2'b00, 2'b10, 2'b10, 7'b0001000);
        e_dec    = mk(4'b0010, 2'b01, 2'b01, 2'b00, 7'b0000000);
        e_wb     = mk(4'b0010, 2'b00, 2'b00, 2'b00, 7'b0000010);
        e_madr   = mk(4'b0010, 2'b10, 2'b01, 2'b00, 7'b0000000);
        e_mrd    = mk(4'b0010, 2'b00, 2'b00, 2'b00, 7'b1001000);
        e_mwr    = mk(4'b0010, 2'b00, 2'b00, 2'b00, 7'b1000100);
        e_mwb    = mk(4'b0010, 2'b00, 2'b00, 2'b01, 7'b0000010);
        e_trap   = mk(4'b0010, 2'b00, 2'b00, 2'b00, 7'b0000001);
        e_zero   = mk(4'b0010, 2'b00, 2'b00, 2'b00, 7'b0000000);
        e_jal    = mk(4'b0010, 2'b01, 2'b10, 2'b00, 7'b0010010);
        e_jalr   = mk(4'b0010, 2'b10, 2'b01, 2'b10, 7'b0010010);
        e_lui    = mk(4'b0010, 2'b11, 2'b01, 2'b10, 7'b0000010);

        instr("add", R, 3'b000, 1'b0);  row("add_execr", R, 3'b000, 1'b0, 1'b0, 1'b1, e_execr(4'b0010));
        row("add_wb", R, 3'b000, 1'b0, 1'b0, 1'b1, e_wb);
        instr("sub", R, 3'b000, 1'b1);  row("sub_execr", R, 3'b000, 1'b1, 1'b0, 1'b1, e_execr(4'b0110));
        row("sub_wb", R, 3'b000, 1'b1, 1'b0, 1'b1, e_wb);
        instr("sltu", R, 3'b011, 1'b0); row("sltu_execr", R, 3'b011, 1'b0, 1'b0, 1'b1, e_execr(4'b1111));
        row("sltu_wb", R, 3'b011, 1'b0, 1'b0, 1'b1, e_wb);
        instr("xor", R, 3'b100, 1'b0);  row("xor_execr", R, 3'b100, 1'b0, 1'b0, 1'b1, e_execr(4'b1010));
        row("xor_wb", R, 3'b100, 1'b0, 1'b0, 1'b1, e_wb);
        instr("srl", R, 3'b101, 1'b0);  row("srl_execr", R, 3'b101, 1'b0, 1'b0, 1'b1, e_execr(4'b1001));
        row("srl_wb", R, 3'b101, 1'b0, 1'b0, 1'b1, e_wb);
        instr("srai", I, 3'b101, 1'b1); row("srai_execi", I, 3'b101, 1'b1, 1'b0, 1'b1, e_execi(4'b0011));
        row("srai_wb", I, 3'b101, 1'b1, 1'b0, 1'b1, e_wb);
        instr("addi", I, 3'b000, 1'b1); row("addi_b5_execi", I, 3'b000, 1'b1, 1'b0, 1'b1, e_execi(4'b0010));
        row("addi_wb", I, 3'b000, 1'b1, 1'b0, 1'b1, e_wb);
        instr("andi", I, 3'b111, 1'b0); row("andi_execi", I, 3'b111, 1'b0, 1'b0, 1'b1, e_execi(4'b0000));
        row("andi_wb", I, 3'b111, 1'b0, 1'b0, 1'b1, e_wb);
        instr("slli", I, 3'b001, 1'b0); row("slli_execi", I, 3'b001, 1'b0, 1'b0, 1'b1, e_execi(4'b1000));
        row("slli_wb", I, 3'b001, 1'b0, 1'b0, 1'b1, e_wb);

        row("lw_fetch_wait", LD, 3'b010, 1'b0, 1'b0, 1'b0, e_f_wait);
        instr("lw", LD, 3'b010, 1'b0);
        row("lw_memadr", LD, 3'b010, 1'b0, 1'b0, 1'b0, e_madr);
        for (int k = 0; k < 3; k++) row("lw_memread_wait", LD, 3'b010, 1'b0, 1'b0, 1'b0, e_mrd);
        row("lw_memread_done", LD, 3'b010, 1'b0, 1'b0, 1'b1, e_mrd);
        row("lw_memwb", LD, 3'b010, 1'b0, 1'b0, 1'b1, e_mwb);
        instr("sw", ST, 3'b010, 1'b0);
        row("sw_memadr", ST, 3'b010, 1'b0, 1'b0, 1'b1, e_madr);
        row("sw_memwrite", ST, 3'b010, 1'b0, 1'b0, 1'b1, e_mwr);

        instr("bge", B, 3'b101, 1'b0);  row("bge_z1_taken", B, 3'b101, 1'b0, 1'b1, 1'b1, e_br(4'b0111, 1'b1));
        instr("bne", B, 3'b001, 1'b0);  row("bne_z1_not", B, 3'b001, 1'b0, 1'b1, 1'b1, e_br(4'b0110, 1'b0));
        instr("beq", B, 3'b000, 1'b0);  row("beq_z1_taken", B, 3'b000, 1'b0, 1'b1, 1'b1, e_br(4'b0110, 1'b1));
        instr("blt", B, 3'b100, 1'b0);  row("blt_z0_taken", B, 3'b100, 1'b0, 1'b0, 1'b1, e_br(4'b0111, 1'b1));
        instr("bltu", B, 3'b110, 1'b0); row("bltu_z0_taken", B, 3'b110, 1'b0, 1'b0, 1'b1, e_br(4'b1111, 1'b1));
        instr("bgeu", B, 3'b111, 1'b0); row("bgeu_z0_not", B, 3'b111, 1'b0, 1'b0, 1'b1, e_br(4'b1111, 1'b0));
        instr("jal", JAL, 3'b000, 1'b0);   row("jal_jump", JAL, 3'b000, 1'b0, 1'b0, 1'b1, e_jal);
        instr("jalr", JALR, 3'b000, 1'b0); row("jalr_jump", JALR, 3'b000, 1'b0, 1'b0, 1'b1, e_jalr);
        instr("lui", LUIOP, 3'b000, 1'b0); row("lui_exec", LUIOP, 3'b000, 1'b0, 1'b0, 1'b1, e_lui);
        instr("bad", BAD, 3'b000, 1'b0);
        row("bad_trap", BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_trap);
        row("bad_trap_sticky", R, 3'b000, 1'b0, 1'b0, 1'b1, e_trap);

        repeat (2) @(negedge clk);
        #1 check("reset_outputs", e_zero);
        @(negedge clk);
        rst = 1'b0;
        run_vecs();

        // Reset out of TRAP, then an illegal branch funct3 also traps
        rst = 1'b1;
        #1 check("trap_reset_clears", e_zero);
        @(negedge clk);
        rst = 1'b0;
        instr("b010", B, 3'b010, 1'b0);
        row("b010_branch", B, 3'b010, 1'b0, 1'b1, 1'b1, e_br(4'b0010, 1'b0));
        row("b010_trap", B, 3'b010, 1'b0, 1'b1, 1'b1, e_trap);
        run_vecs();

        // Reset asserted mid-MEMWRITE
        rst = 1'b1;
        #1 check("trap_reset_clears2", e_zero);
        @(negedge clk);
        rst = 1'b0;
        instr("sw2", ST, 3'b010, 1'b0);
        row("sw2_memadr", ST, 3'b010, 1'b0, 1'b0, 1'b0, e_madr);
        row("sw2_memwrite_wait", ST, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr);
        run_vecs();
        #1 check("sw2_memwrite_still", e_mwr);
        #1 rst = 1'b1;
        #1 check("rst_mid_memwrite", e_zero);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 check("fetch_after_rst_wait", e_f_wait);
        mem_ready = 1'b1;
        #1 check("fetch_after_rst_ready", e_f_rdy);
        @(negedge clk);
        opcode = R;
        #1 check("decode_after_rst", e_dec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 clk  in  1  rising-edge clock; the block has one clock.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 opcode  in  7  instruction[6:0] from the instruction register; sampled in DECODE.
REQ-004 funct3  in  3  instruction[14:12].
REQ-005 funct7b5  in  1  instruction[30].
REQ-006 zero  in  1  ALU zero flag; used only in BRANCH.
REQ-007 mem_ready  in  1  memory handshake; the current access completes in the cycle it is high.
REQ-008 alu_control  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1111, XOR 1010, SLL 1000, SRL 1001, SRA 0011.
REQ-009 alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
REQ-010 alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-011 result_src  out  2  00 ALU-out register, 01 memory data, 10 live ALU result.
REQ-012 adr_src, ir_write, pc_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-013 illegal  out  1  sticky flag for an unsupported opcode.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JUMP, LUI, TRAP.
REQ-015 FETCH: mem_read=1, adr_src=0, src_a=00, src_b=10, alu=ADD, result_src=10; while mem_ready=0, stay with ir_write=0 and pc_write=0; when mem_ready=1, assert ir_write=1 and pc_write=1 for that cycle only, then go to DECODE.
REQ-016 DECODE: src_a=01, src_b=01, alu=ADD (branch target to the ALU-out register); next state: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 or 1100111 -> JUMP, 0110111 -> LUI, any other -> TRAP.
REQ-017 MEMADR: src_a=10, src_b=01, alu=ADD; loads go to MEMREAD, stores go to MEMWRITE.
REQ-018 MEMREAD and MEMWRITE: adr_src=1 and mem_read or mem_write held; wait until mem_ready=1; MEMREAD then goes to MEMWB, MEMWRITE then goes to FETCH.
REQ-019 MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-020 EXECR: src_a=10, src_b=00; alu from funct3/funct7b5: 000 ADD (SUB if b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if b5=1), 110 OR, 111 AND -> ALUWB.
REQ-021 EXECI: same table with src_b=01; funct7b5 is honoured only for funct3=101 (ADDI never becomes SUB) -> ALUWB.
REQ-022 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-023 BRANCH: src_a=10, src_b=00, result_src=00; beq/bne use SUB, blt/bge use SLT, bltu/bgeu use SLTU.
REQ-024 BRANCH taken condition: beq/bge/bgeu when zero=1; bne/blt/bltu when zero=0; pc_write equals the taken condition combinationally in this cycle; funct3 010/011 -> TRAP; otherwise -> FETCH.
REQ-025 JUMP: reg_write=1 with result_src=00 (PC+4 via old PC); pc_write=1; jal uses the DECODE target, jalr uses rs1+imm live with result_src=10 -> FETCH.
REQ-026 LUI: src_b=01 with zero-base operand select, alu=ADD, result_src=10, reg_write=1 -> FETCH.
REQ-027 TRAP: illegal=1; all strobes 0; remains in TRAP until rst.
REQ-028 Any strobe not listed for a state SHALL be 0; alu_control SHALL default to ADD.
REQ-029 Latency in cycles with zero memory wait: R/I-type 4, load 5, store 4, branch 3, jump 3, LUI 3.

Reset
REQ-030 rst high SHALL immediately force state FETCH, illegal=0, and all strobes to 0 asynchronously; mid-wait reset abandons the access.
REQ-031 After rst deasserts, FETCH behaves as in REQ-015 from the next rising edge.

Structure
REQ-032 Package ctrl_pkg SHALL hold the ALU op constants, the opcode constants, the src/result select encodings and the state enum.
REQ-033 Sub-module alu_decoder (combinational: opcode class, funct3, funct7b5 -> alu_control) SHALL be instantiated once.

Verification
REQ-034 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECR(alu 0010),ALUWB(reg_write=1),FETCH in 4 cycles.
REQ-035 sub / srai -> EXECR alu=0110; EXECI with funct3=101, b5=1 -> alu=0011; addi with b5=1 -> 0010.
REQ-036 lw with mem_ready low 3 cycles in MEMREAD -> mem_read held 3 cycles, no reg_write until MEMWB.
REQ-037 bge with zero=1 -> alu=0111, pc_write=1; bne with zero=1 -> pc_write=0.
REQ-038 opcode 0x7F -> TRAP, illegal=1 sticky; rst pulse -> FETCH, illegal=0.
REQ-039 rst asserted mid-MEMWRITE -> mem_write=0 the same cycle, state FETCH.
